// File: rtl/structs_pkg.sv
// Shared types for the indirect-target queue.
// itq_entry_t : one queue slot (valid, producer tag, base, immediate, predicted target)
// ITQ_TAG_READY : tag value meaning "base operand already holds its value"
// itq_calc_target : jump target computation, (base + imm) with bit 0 cleared
package structs_pkg;

    localparam int ITQ_TAG_W = 4;
    localparam int ITQ_XLEN  = 32;

    localparam logic [ITQ_TAG_W-1:0] ITQ_TAG_READY = '0;

    typedef struct packed {
        logic                 valid;
        logic [ITQ_TAG_W-1:0] tag;
        logic [ITQ_XLEN-1:0]  base;
        logic [ITQ_XLEN-1:0]  imm;
        logic [ITQ_XLEN-1:0]  pred;
    } itq_entry_t;

    function automatic logic [ITQ_XLEN-1:0] itq_calc_target(
        input logic [ITQ_XLEN-1:0] base,
        input logic [ITQ_XLEN-1:0] imm
    );
        logic [ITQ_XLEN-1:0] sum;
        sum    = base + imm;
        sum[0] = 1'b0;
        return sum;
    endfunction

endpackage

// File: rtl/itq_target_queue_if.sv
// Bundle between the queue and its surroundings (front end, CDB, commit).
// master : front end / CDB / commit side, drives requests and broadcasts
// slave  : the queue, drives enq_ready, head_* and count
interface itq_target_queue_if #(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32
);
    logic                      flush;
    logic                      enq_valid;
    logic [TAG_W-1:0]          enq_tag;
    logic [XLEN-1:0]           enq_base;
    logic [XLEN-1:0]           enq_imm;
    logic [XLEN-1:0]           enq_pred;
    logic                      enq_ready;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]   cdb_result;
    logic [NUM_CDB-1:0]        cdb_load_step1;
    logic                      deq_en;
    logic                      head_ready;
    logic [XLEN-1:0]           head_target;
    logic [XLEN-1:0]           head_pred;
    logic                      head_mispredict;
    logic [$clog2(DEPTH):0]    count;

    modport master (
        output flush, enq_valid, enq_tag, enq_base, enq_imm, enq_pred,
        output cdb_valid, cdb_tag, cdb_result, cdb_load_step1, deq_en,
        input  enq_ready, head_ready, head_target, head_pred, head_mispredict, count
    );

    modport slave (
        input  flush, enq_valid, enq_tag, enq_base, enq_imm, enq_pred,
        input  cdb_valid, cdb_tag, cdb_result, cdb_load_step1, deq_en,
        output enq_ready, head_ready, head_target, head_pred, head_mispredict, count
    );

endinterface

// File: rtl/itq_cdb_match.sv
// Matches one producer tag against all CDB broadcast ports.
// tag            : tag being waited on (0 = ready, never matches)
// cdb_*          : broadcast ports, packed per port
// hit / value    : a forwardable broadcast matched; value from the lowest-index matching port
module itq_cdb_match #(
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32
)(
    input  logic [TAG_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_result,
    input  logic [NUM_CDB-1:0]       cdb_load_step1,
    output logic                     hit,
    output logic [XLEN-1:0]          value
);

    // Scan from the highest port down so the lowest matching port is written last.
    // Address-phase load broadcasts carry no data and are never forwarded.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if ((tag != '0) && cdb_valid[p] && !cdb_load_step1[p] &&
                (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
                hit   = 1'b1;
                value = cdb_result[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/itq_target_queue.sv
// Indirect-jump target queue: holds base/imm/pred for in-flight indirect jumps,
// waits for the base register on the CDB, and presents the head target and
// mispredict indication to commit.
// clk, reset : clock, synchronous active-high reset
// bus        : itq_target_queue_if slave (enqueue, CDB, dequeue, head outputs, count)
// Entry widths come from structs_pkg; TAG_W/XLEN must equal ITQ_TAG_W/ITQ_XLEN.
module itq_target_queue
    import structs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = ITQ_TAG_W,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = ITQ_XLEN
)(
    input  logic              clk,
    input  logic              reset,
    itq_target_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    itq_entry_t       q [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;

    logic [DEPTH-1:0] ent_hit;
    logic [XLEN-1:0]  ent_val [DEPTH];
    logic             enq_hit;
    logic [XLEN-1:0]  enq_val;

    logic             do_enq;
    logic             do_deq;
    logic             enq_ready_int;
    itq_entry_t       enq_entry;
    itq_entry_t       head;
    logic             head_ready_int;
    logic [XLEN-1:0]  head_tgt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_match
        itq_cdb_match #(
            .TAG_W   (TAG_W),
            .NUM_CDB (NUM_CDB),
            .XLEN    (XLEN)
        ) u_match (
            .tag            (TAG_W'(q[i].tag)),
            .cdb_valid      (bus.cdb_valid),
            .cdb_tag        (bus.cdb_tag),
            .cdb_result     (bus.cdb_result),
            .cdb_load_step1 (bus.cdb_load_step1),
            .hit            (ent_hit[i]),
            .value          (ent_val[i])
        );
    end

    // Bypass path: an entry written this cycle also sees this cycle's broadcasts.
    itq_cdb_match #(
        .TAG_W   (TAG_W),
        .NUM_CDB (NUM_CDB),
        .XLEN    (XLEN)
    ) u_enq_match (
        .tag            (bus.enq_tag),
        .cdb_valid      (bus.cdb_valid),
        .cdb_tag        (bus.cdb_tag),
        .cdb_result     (bus.cdb_result),
        .cdb_load_step1 (bus.cdb_load_step1),
        .hit            (enq_hit),
        .value          (enq_val)
    );

    assign enq_ready_int = (cnt != CNT_W'(DEPTH));
    assign do_enq        = bus.enq_valid && enq_ready_int;
    assign do_deq        = bus.deq_en && (cnt != '0);

    always_comb begin
        enq_entry       = '0;
        enq_entry.valid = 1'b1;
        enq_entry.imm   = ITQ_XLEN'(bus.enq_imm);
        enq_entry.pred  = ITQ_XLEN'(bus.enq_pred);
        if (enq_hit) begin
            enq_entry.tag  = ITQ_TAG_READY;
            enq_entry.base = ITQ_XLEN'(enq_val);
        end else begin
            enq_entry.tag  = ITQ_TAG_W'(bus.enq_tag);
            enq_entry.base = ITQ_XLEN'(bus.enq_base);
        end
    end

    // Reset and flush clear the same state; reset is listed first so it
    // dominates everything, flush then dominates enq/deq/capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i].valid <= 1'b0;
            end
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid && (q[i].tag != ITQ_TAG_READY) && ent_hit[i]) begin
                    q[i].tag  <= ITQ_TAG_READY;
                    q[i].base <= ITQ_XLEN'(ent_val[i]);
                end
            end

            if (do_deq) begin
                q[rptr].valid <= 1'b0;
                rptr          <= rptr + PTR_W'(1);
            end

            // wptr never equals an occupied slot when not full, so this write
            // cannot collide with the capture or dequeue updates above.
            if (do_enq) begin
                q[wptr] <= enq_entry;
                wptr    <= wptr + PTR_W'(1);
            end

            case ({do_enq, do_deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head           = q[rptr];
    assign head_ready_int = (cnt != '0) && head.valid && (head.tag == ITQ_TAG_READY);
    assign head_tgt       = XLEN'(itq_calc_target(head.base, head.imm));

    assign bus.enq_ready       = enq_ready_int;
    assign bus.head_ready      = head_ready_int;
    assign bus.head_target     = head_tgt;
    assign bus.head_pred       = XLEN'(head.pred);
    assign bus.head_mispredict = head_ready_int && (head_tgt != XLEN'(head.pred));
    assign bus.count           = cnt;

endmodule

// File: tb/tb_itq_target_queue.sv
module tb_itq_target_queue;

    localparam int DEPTH   = 8;
    localparam int TAG_W   = 4;
    localparam int NUM_CDB = 2;
    localparam int XLEN    = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    itq_target_queue_if #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)
    ) bus ();

    itq_target_queue #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] pred;
    } m_ent_t;

    m_ent_t mq[$];

    int checks = 0;
    int errors = 0;

    logic        r_reset, r_flush, e_valid, d_en;
    logic [3:0]  e_tag;
    logic [31:0] e_base, e_imm, e_pred;
    logic        c_valid [2];
    logic [3:0]  c_tag   [2];
    logic [31:0] c_res   [2];
    logic        c_ls    [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        r_reset = 1'b0; r_flush = 1'b0; e_valid = 1'b0; d_en = 1'b0;
        e_tag = 4'd0; e_base = '0; e_imm = '0; e_pred = '0;
        for (int p = 0; p < 2; p++) begin
            c_valid[p] = 1'b0; c_tag[p] = 4'd0; c_res[p] = '0; c_ls[p] = 1'b0;
        end
    endtask

    function automatic int hit_port(input logic [3:0] t);
        for (int p = 0; p < 2; p++)
            if (t != 4'd0 && c_valid[p] && !c_ls[p] && c_tag[p] == t) return p;
        return -1;
    endfunction

    // Queue-level reference: what the spec says happens to the list of pending jumps.
    task automatic model_step();
        int n0;
        int p;
        bit do_enq;
        m_ent_t e;
        if (r_reset || r_flush) begin
            mq.delete();
        end else begin
            n0 = mq.size();
            foreach (mq[i]) begin
                if (mq[i].tag != 4'd0) begin
                    p = hit_port(mq[i].tag);
                    if (p >= 0) begin
                        mq[i].base = c_res[p];
                        mq[i].tag  = 4'd0;
                    end
                end
            end
            do_enq = e_valid && (n0 < DEPTH);
            if (d_en && n0 > 0) void'(mq.pop_front());
            if (do_enq) begin
                e.tag = e_tag; e.base = e_base; e.imm = e_imm; e.pred = e_pred;
                p = hit_port(e_tag);
                if (p >= 0) begin
                    e.base = c_res[p];
                    e.tag  = 4'd0;
                end
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        int n;
        bit exp_hr;
        logic [31:0] tgt;
        n = mq.size();
        chk("count", 64'(bus.count), 64'(n));
        chk("enq_ready", 64'(bus.enq_ready), 64'(n < DEPTH));
        exp_hr = (n > 0) && (mq[0].tag == 4'd0);
        chk("head_ready", 64'(bus.head_ready), 64'(exp_hr));
        if (exp_hr) begin
            tgt = (mq[0].base + mq[0].imm) & ~32'h1;
            chk("head_target", 64'(bus.head_target), 64'(tgt));
            chk("head_pred", 64'(bus.head_pred), 64'(mq[0].pred));
            chk("head_mispredict", 64'(bus.head_mispredict), 64'(tgt != mq[0].pred));
        end else begin
            chk("head_mispredict_idle", 64'(bus.head_mispredict), 64'd0);
        end
    endtask

    task automatic cycle();
        reset              = r_reset;
        bus.flush          = r_flush;
        bus.enq_valid      = e_valid;
        bus.enq_tag        = e_tag;
        bus.enq_base       = e_base;
        bus.enq_imm        = e_imm;
        bus.enq_pred       = e_pred;
        bus.deq_en         = d_en;
        bus.cdb_valid      = {c_valid[1], c_valid[0]};
        bus.cdb_tag        = {c_tag[1], c_tag[0]};
        bus.cdb_result     = {c_res[1], c_res[0]};
        bus.cdb_load_step1 = {c_ls[1], c_ls[0]};
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic enq(input logic [3:0] t, input logic [31:0] b, input logic [31:0] i,
                       input logic [31:0] pr);
        e_valid = 1'b1; e_tag = t; e_base = b; e_imm = i; e_pred = pr;
    endtask

    initial begin
        idle();
        @(negedge clk);

        r_reset = 1'b1;
        cycle();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        chk("rst_head_ready", 64'(bus.head_ready), 64'd0);

        // resolved base at enqueue
        idle(); enq(4'd0, 32'h1000, 32'h11, 32'h1010); cycle();
        chk("ready_hr", 64'(bus.head_ready), 64'd1);
        chk("ready_tgt", 64'(bus.head_target), 64'h1010);
        chk("ready_mp", 64'(bus.head_mispredict), 64'd0);
        idle(); d_en = 1'b1; cycle();
        idle(); d_en = 1'b1; cycle();
        chk("deq_empty_count", 64'(bus.count), 64'd0);

        // wakeup from CDB port 1
        idle(); enq(4'd3, 32'hdead, 32'h4, 32'h2000); cycle();
        chk("wake_pending", 64'(bus.head_ready), 64'd0);
        idle(); c_valid[1] = 1'b1; c_tag[1] = 4'd3; c_res[1] = 32'h2000;
        c_valid[0] = 1'b1; c_tag[0] = 4'd4; c_res[0] = 32'h5555; cycle();
        chk("wake_hr", 64'(bus.head_ready), 64'd1);
        chk("wake_tgt", 64'(bus.head_target), 64'h2004);
        chk("wake_mp", 64'(bus.head_mispredict), 64'd1);
        idle(); d_en = 1'b1; cycle();

        // same-cycle bypass
        idle(); enq(4'd5, 32'h0, 32'h8, 32'h48);
        c_valid[0] = 1'b1; c_tag[0] = 4'd5; c_res[0] = 32'h40; cycle();
        chk("bypass_hr", 64'(bus.head_ready), 64'd1);
        chk("bypass_tgt", 64'(bus.head_target), 64'h48);
        idle(); d_en = 1'b1; cycle();

        // tag-0 broadcast never matches
        idle(); enq(4'd0, 32'h100, 32'h0, 32'h100); cycle();
        idle(); c_valid[0] = 1'b1; c_tag[0] = 4'd0; c_res[0] = 32'hdead0; cycle();
        chk("tag0_tgt", 64'(bus.head_target), 64'h100);
        idle(); d_en = 1'b1; cycle();

        // both ports match: lowest wins
        idle(); enq(4'd6, 32'h0, 32'h2, 32'h0); cycle();
        idle(); c_valid[0] = 1'b1; c_tag[0] = 4'd6; c_res[0] = 32'h10;
        c_valid[1] = 1'b1; c_tag[1] = 4'd6; c_res[1] = 32'h20; cycle();
        chk("prio_tgt", 64'(bus.head_target), 64'h12);
        idle(); d_en = 1'b1; cycle();

        // fill, overflow, full enq+deq, drain in order (pointers wrap)
        for (int i = 0; i < DEPTH; i++) begin
            idle(); enq(4'd0, 32'h100 * (i + 1), 32'h0, 32'h100 * (i + 1)); cycle();
        end
        chk("full_count", 64'(bus.count), 64'd8);
        chk("full_enq_ready", 64'(bus.enq_ready), 64'd0);
        idle(); enq(4'd0, 32'hffff0, 32'h0, 32'h0); cycle();
        chk("drop_count", 64'(bus.count), 64'd8);
        idle(); enq(4'd0, 32'heeee0, 32'h0, 32'h0); d_en = 1'b1; cycle();
        chk("full_enqdeq_count", 64'(bus.count), 64'd7);
        for (int i = 1; i < DEPTH; i++) begin
            chk("fifo_order", 64'(bus.head_target), 64'(32'h100 * (i + 1)));
            idle(); d_en = 1'b1; cycle();
        end
        chk("drained_count", 64'(bus.count), 64'd0);
        idle(); enq(4'd0, 32'h777, 32'h0, 32'h776); cycle();
        chk("wrap_tgt", 64'(bus.head_target), 64'h776);
        idle(); d_en = 1'b1; cycle();

        // load step1 does not forward; flush beats enq/deq
        idle(); enq(4'd2, 32'h0, 32'h0, 32'h0); cycle();
        idle(); c_valid[0] = 1'b1; c_tag[0] = 4'd2; c_res[0] = 32'h9999; c_ls[0] = 1'b1; cycle();
        chk("ls1_hr", 64'(bus.head_ready), 64'd0);
        idle(); enq(4'd0, 32'h10, 32'h0, 32'h0); cycle();
        idle(); enq(4'd0, 32'h20, 32'h0, 32'h0); cycle();
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        idle(); r_flush = 1'b1; enq(4'd0, 32'h30, 32'h0, 32'h0); d_en = 1'b1; cycle();
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_hr", 64'(bus.head_ready), 64'd0);

        // randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            idle();
            r_reset = ($urandom_range(0, 199) == 0);
            r_flush = ($urandom_range(0, 39) == 0);
            e_valid = ($urandom_range(0, 9) < 6);
            e_tag   = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
            e_base  = $urandom;
            e_imm   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
            e_pred  = $urandom_range(0, 1) ? ((e_base + e_imm) & ~32'h1) : $urandom;
            d_en    = ($urandom_range(0, 9) < 4);
            for (int p = 0; p < 2; p++) begin
                c_valid[p] = 1'($urandom_range(0, 1));
                c_tag[p]   = 4'($urandom_range(0, 7));
                c_res[p]   = $urandom;
                c_ls[p]    = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
